// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: in-order requests on an SRAM-like bus, a small
// PC/instruction queue toward decode, and redirect flushing with response drop.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_adel
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = CW1'(DEPTH);

  logic [31:0]      pc_f_q, pc_f_d;
  logic [PW-1:0]    head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic             halt_q, halt_d;
  logic [31:0]      ent_pc_q   [DEPTH];
  logic [31:0]      ent_pc_d   [DEPTH];
  logic [31:0]      ent_inst_q [DEPTH];
  logic [31:0]      ent_inst_d [DEPTH];
  logic [DEPTH-1:0] ent_filled_q, ent_filled_d;
  logic [DEPTH-1:0] ent_adel_q, ent_adel_d;

  logic        accept, misal, alloc_en, fill_en, pop;
  logic [CW:0] occupancy;

  always_comb begin
    occupancy = {1'b0, count_q} + {1'b0, drop_q};
    inst_req  = resetn && !redirect_valid && !halt_q &&
                (occupancy < DEPTH_X) && (pc_f_q[1:0] == 2'b00);
    inst_addr = pc_f_q;
    id_valid  = (count_q != '0) && ent_filled_q[head_q];
    id_inst   = ent_inst_q[head_q];
    id_pc     = ent_pc_q[head_q];
    id_adel   = ent_adel_q[head_q];
    accept    = inst_req && inst_addr_ok;
    // A misaligned PC takes a queue slot as an error marker instead of a bus request.
    misal     = !redirect_valid && !halt_q && (pc_f_q[1:0] != 2'b00) &&
                (count_q != DEPTH_C);
    alloc_en  = accept || misal;
    // pend_q counts entries waiting on the bus; only those can be filled.
    fill_en   = inst_data_ok && !redirect_valid && (drop_q == '0) && (pend_q != '0);
    pop       = id_valid && id_ready && !redirect_valid;
  end

  always_comb begin
    pc_f_d       = pc_f_q;
    head_d       = head_q;
    alloc_d      = alloc_q;
    fill_d       = fill_q;
    halt_d       = halt_q;
    ent_pc_d     = ent_pc_q;
    ent_inst_d   = ent_inst_q;
    ent_filled_d = ent_filled_q;
    ent_adel_d   = ent_adel_q;
    count_d      = count_q + CW'(alloc_en) - CW'(pop);
    pend_d       = pend_q + CW'(accept) - CW'(fill_en);
    drop_d       = drop_q;

    if (alloc_en) begin
      ent_pc_d[alloc_q]     = pc_f_q;
      ent_inst_d[alloc_q]   = '0;
      ent_filled_d[alloc_q] = misal;
      ent_adel_d[alloc_q]   = misal;
      alloc_d               = alloc_q + PW'(1);
    end
    if (fill_en) begin
      ent_inst_d[fill_q]   = inst_rdata;
      ent_filled_d[fill_q] = 1'b1;
      fill_d               = fill_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    if (accept) pc_f_d = pc_f_q + 32'd4;
    if (misal) halt_d = 1'b1;
    if (inst_data_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Redirect: everything still owed by the bus becomes drop credit.
    if (redirect_valid) begin
      count_d = '0;
      pend_d  = '0;
      head_d  = alloc_q;
      fill_d  = alloc_q;
      alloc_d = alloc_q;
      drop_d  = drop_q + pend_q -
                CW'(inst_data_ok && ((drop_q != '0) || (pend_q != '0)));
      pc_f_d  = redirect_pc;
      halt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_f_q       <= RESET_PC;
      head_q       <= '0;
      alloc_q      <= '0;
      fill_q       <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      drop_q       <= '0;
      halt_q       <= 1'b0;
      ent_pc_q     <= '{default: '0};
      ent_inst_q   <= '{default: '0};
      ent_filled_q <= '0;
      ent_adel_q   <= '0;
    end else begin
      pc_f_q       <= pc_f_d;
      head_q       <= head_d;
      alloc_q      <= alloc_d;
      fill_q       <= fill_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      halt_q       <= halt_d;
      ent_pc_q     <= ent_pc_d;
      ent_inst_q   <= ent_inst_d;
      ent_filled_q <= ent_filled_d;
      ent_adel_q   <= ent_adel_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_adel;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_pc(id_pc), .id_adel(id_adel)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
    bit          adel;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc_f = RST_PC;
  int          m_drop = 0;
  bit          m_halt = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] bus_q[$];
  bit          resp_en = 1'b0;
  int          n_acc = 0;
  bit          pop_seen;
  logic [31:0] pop_pc, pop_inst;

  function automatic bit m_req();
    return resetn && !redirect_valid && !m_halt &&
           (mq.size() + m_drop < DEPTH) && (m_pc_f[1:0] == 2'b00);
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && mq[0].filled;
  endfunction

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue entry per allocation, responses fill the oldest unfilled one.
  bit m_r, m_v, m_mis, m_done;
  int m_sz, m_u;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_pc_f = RST_PC;
      m_drop = 0;
      m_halt = 1'b0;
    end else begin
      m_r  = m_req();
      m_v  = m_valid();
      m_sz = mq.size();
      if (redirect_valid) begin
        m_u    = m_unfilled();
        m_drop = m_drop + m_u - ((inst_data_ok && (m_drop + m_u > 0)) ? 1 : 0);
        mq.delete();
        m_pc_f = redirect_pc;
        m_halt = 1'b0;
      end else begin
        m_mis = !m_halt && (m_pc_f[1:0] != 2'b00) && (m_sz < DEPTH);
        if (inst_data_ok) begin
          if (m_drop > 0) m_drop--;
          else begin
            m_done = 1'b0;
            foreach (mq[i])
              if (!m_done && !mq[i].filled) begin
                mq[i].inst   = inst_rdata;
                mq[i].filled = 1'b1;
                m_done       = 1'b1;
              end
          end
        end
        if (m_v && id_ready) void'(mq.pop_front());
        if (m_r && inst_addr_ok) begin
          mq.push_back('{m_pc_f, 32'd0, 1'b0, 1'b0});
          m_pc_f = m_pc_f + 32'd4;
        end else if (m_mis) begin
          mq.push_back('{m_pc_f, 32'd0, 1'b1, 1'b1});
          m_halt = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("inst_req", {31'd0, inst_req}, {31'd0, m_req()});
      if (m_req()) check("inst_addr", inst_addr, m_pc_f);
      check("id_valid", {31'd0, id_valid}, {31'd0, m_valid()});
      if (m_valid()) begin
        check("id_pc", id_pc, mq[0].pc);
        check("id_inst", id_inst, mq[0].inst);
        check("id_adel", {31'd0, id_adel}, {31'd0, mq[0].adel});
      end
    end
  end

  task automatic drive_bus();
    inst_data_ok = resp_en && (bus_q.size() > 0);
    inst_rdata   = (bus_q.size() > 0) ? (bus_q[0] ^ 32'h1234) : 32'd0;
  endtask

  task automatic tick();
    logic        acc, rsp;
    logic [31:0] a;
    @(negedge clk);
    acc      = inst_req && inst_addr_ok;
    a        = inst_addr;
    rsp      = inst_data_ok;
    pop_seen = id_valid && id_ready;
    pop_pc   = id_pc;
    pop_inst = id_inst;
    @(posedge clk);
    if (rsp && (bus_q.size() > 0)) void'(bus_q.pop_front());
    if (acc) begin
      bus_q.push_back(a);
      n_acc++;
    end
    #1;
    drive_bus();
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    inst_addr_ok   = 1'b0;
    resp_en        = 1'b0;
    bus_q.delete();
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_req", {31'd0, inst_req}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_id_adel", {31'd0, id_adel}, 32'd0);
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int          pops;
    logic [31:0] exp_pc;
    bit          got;

    // Streaming fetch with decode always ready.
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1; id_ready = 1'b1;
    check("s1_first_addr", inst_addr, RST_PC);
    exp_pc = RST_PC;
    pops   = 0;
    repeat (12) begin
      tick();
      if (pop_seen) begin
        check("s1_pop_pc", pop_pc, exp_pc);
        check("s1_pop_inst", pop_inst, exp_pc ^ 32'h1234);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    check("s1_pops", pops, 32'd10);

    // Decode stalled: queue fills after DEPTH accepts, then resumes.
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1;
    n_acc = 0;
    repeat (8) tick();
    check("s2_accepts", n_acc, DEPTH);
    check("s2_req_full", {31'd0, inst_req}, 32'd0);
    check("s2_head_pc", id_pc, RST_PC);
    check("s2_head_inst", id_inst, RST_PC ^ 32'h1234);
    id_ready = 1'b1;
    tick();
    check("s2_resume_req", {31'd0, inst_req}, 32'd1);
    check("s2_resume_addr", inst_addr, 32'hBFC00010);
    repeat (6) tick();

    // Redirect with three outstanding and a response in the same cycle.
    do_reset();
    inst_addr_ok = 1'b1;
    repeat (3) tick();
    inst_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80000100;
    resp_en = 1'b1; drive_bus();
    #1;
    check("s3_redir_req", {31'd0, inst_req}, 32'd0);
    check("s3_redir_data_ok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    check("s3_model_drop", m_drop, 32'd2);
    redirect_valid = 1'b0; inst_addr_ok = 1'b1; id_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (pop_seen) begin
        got = 1'b1;
        check("s3_first_pc", pop_pc, 32'h80000100);
        check("s3_first_inst", pop_inst, 32'h80000100 ^ 32'h1234);
      end
    end
    if (!got) check("s3_pop_timeout", 32'd0, 32'd1);

    // addr_ok held low; redirect in cycle 3 retargets the request.
    do_reset();
    id_ready = 1'b1; resp_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      redirect_valid = (c == 3);
      redirect_pc    = 32'h80000200;
      #1;
      if (c < 3) begin
        check("s4_req_hold", {31'd0, inst_req}, 32'd1);
        check("s4_addr_hold", inst_addr, RST_PC);
      end else if (c == 3) begin
        check("s4_req_redir", {31'd0, inst_req}, 32'd0);
      end else begin
        check("s4_req_new", {31'd0, inst_req}, 32'd1);
        check("s4_addr_new", inst_addr, 32'h80000200);
      end
      tick();
    end
    redirect_valid = 1'b0;

    // Misaligned redirect target halts fetch and reports an address error.
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s5_no_req", {31'd0, inst_req}, 32'd0);
    tick();
    #1;
    check("s5_valid", {31'd0, id_valid}, 32'd1);
    check("s5_adel", {31'd0, id_adel}, 32'd1);
    check("s5_pc", id_pc, 32'h80000102);
    check("s5_inst", id_inst, 32'd0);
    repeat (3) tick();
    check("s5_still_halted", {31'd0, inst_req}, 32'd0);
    check("s5_pc_stable", id_pc, 32'h80000102);
    id_ready = 1'b1;
    tick();
    #1;
    check("s5_popped", {31'd0, id_valid}, 32'd0);
    repeat (2) tick();
    check("s5_halt_after_pop", {31'd0, inst_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h80000300;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s5_restart_req", {31'd0, inst_req}, 32'd1);
    check("s5_restart_addr", inst_addr, 32'h80000300);
    repeat (6) tick();

    // Mixed handshakes with a mid-run redirect.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      inst_addr_ok   = (i % 3) != 0;
      id_ready       = (i % 2) == 1;
      resp_en        = (i % 4) != 1;
      redirect_valid = (i == 15);
      redirect_pc    = 32'h80001000;
      drive_bus();
      tick();
    end
    redirect_valid = 1'b0;

    // Reset asserted mid-stream with a full queue.
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1;
    repeat (8) tick();
    check("s6_full_req", {31'd0, inst_req}, 32'd0);
    check("s6_full_valid", {31'd0, id_valid}, 32'd1);
    resetn = 1'b0;
    bus_q.delete();
    resp_en = 1'b0;
    drive_bus();
    #1;
    check("s6_rst_valid", {31'd0, id_valid}, 32'd0);
    check("s6_rst_req", {31'd0, inst_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1; resp_en = 1'b1; id_ready = 1'b1;
    #1;
    check("s6_first_req", {31'd0, inst_req}, 32'd1);
    check("s6_first_addr", inst_addr, RST_PC);
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
    $fatal(1);
  end

endmodule
